// File: rtl/cdr_phase_tracker_if.sv
// rtl/cdr_phase_tracker_if.sv - stream channel carrying recovered words out of cdr_phase_tracker
interface cdr_phase_tracker_if #(
    parameter int TDATA_WIDTH = 8
);
    logic                   m_tvalid;
    logic                   m_tready;
    logic [TDATA_WIDTH-1:0] m_tdata;

    modport master (output m_tvalid, output m_tdata, input m_tready);
    modport slave  (input m_tvalid, input m_tdata, output m_tready);
endinterface

// File: rtl/cdr_phase_tracker.sv
// rtl/cdr_phase_tracker.sv - oversampling CDR back end: edge detect, phase track, deserialise, FIFO
// Optional two-event phase hysteresis enabled by defining CDR_PHASE_HYSTERESIS_EN.
module cdr_phase_tracker #(
    parameter int N_PHASES    = 4,
    parameter int TDATA_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [N_PHASES-1:0]         s_samples,
    cdr_phase_tracker_if.master         m,
    output logic                        locked,
    output logic [$clog2(N_PHASES)-1:0] phase,
    output logic                        overflow
);
    localparam int PW = $clog2(N_PHASES);
    localparam int CW = $clog2(TDATA_WIDTH + 2);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] HALF_P   = PW'(N_PHASES / 2);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

    localparam logic [0:0] ST_ACQ   = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    logic [N_PHASES-1:0] s_q;
    logic                l_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_q <= '0;
            l_q <= 1'b0;
        end else begin
            s_q <= s_samples;
            l_q <= s_q[N_PHASES-1];
        end
    end

    logic [N_PHASES-1:0] trans;
    logic [PW-1:0]       e_pos;
    logic [PW-1:0]       cand;
    logic                edge_ev;

    always_comb begin
        trans = s_q ^ {s_q[N_PHASES-2:0], l_q};
        e_pos = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            if (trans[i]) e_pos = PW'(i);
        end
        edge_ev = $onehot(trans);
        cand    = e_pos + HALF_P;
    end

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          locked_q;
    logic [1:0]    nb_q, nb_d;
    logic          b0_q, b0_d, b1_q, b1_d;
`ifdef CDR_PHASE_HYSTERESIS_EN
    logic [PW-1:0] pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
`endif

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        lcnt_d  = lcnt_q;
        nb_d    = 2'd0;
        b0_d    = 1'b0;
        b1_d    = 1'b0;
`ifdef CDR_PHASE_HYSTERESIS_EN
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
`endif
        if (state_q == ST_ACQ) begin
            if (edge_ev) begin
                state_d = ST_TRACK;
                p_d     = cand;
                lcnt_d  = '0;
                nb_d    = 2'd1;
                b0_d    = s_q[cand];
`ifdef CDR_PHASE_HYSTERESIS_EN
                pend_v_d = 1'b0;
`endif
            end
        end else begin
            if (edge_ev) begin
`ifdef CDR_PHASE_HYSTERESIS_EN
                // A disagreeing candidate must repeat on the next edge event to be adopted
                if (cand == p_q) begin
                    pend_v_d = 1'b0;
                end else if (pend_v_q && pend_q == cand) begin
                    p_d      = cand;
                    pend_v_d = 1'b0;
                end else begin
                    pend_d   = cand;
                    pend_v_d = 1'b1;
                end
`else
                p_d = cand;
`endif
                if (p_d != p_q)
                    lcnt_d = '0;
                else if (lcnt_q < LOCK_MAX)
                    lcnt_d = lcnt_q + LW'(1);
            end
            if (p_q > p_d && (p_q - p_d) > HALF_P) begin
                nb_d = 2'd0;
            end else if (p_d > p_q && (p_d - p_q) > HALF_P) begin
                nb_d = 2'd2;
                b0_d = s_q[p_q];
                b1_d = s_q[p_d];
            end else begin
                nb_d = 2'd1;
                b0_d = s_q[p_d];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_ACQ;
            p_q      <= '0;
            lcnt_q   <= '0;
            locked_q <= 1'b0;
            nb_q     <= 2'd0;
            b0_q     <= 1'b0;
            b1_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            lcnt_q   <= lcnt_d;
            locked_q <= (lcnt_d >= LOCK_MAX);
            nb_q     <= nb_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
        end
    end

`ifdef CDR_PHASE_HYSTERESIS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end
`endif

    assign phase  = p_q;
    assign locked = locked_q;

    logic [TDATA_WIDTH:0]   sr_q, sr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   push_q, push_d;
    logic [TDATA_WIDTH-1:0] word_q, word_d;

    // Bits enter at the MSB; a count of W+1 means the newest bit belongs to the next word
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        push_d = 1'b0;
        word_d = word_q;
        if (nb_q == 2'd1) begin
            sr_d  = {b0_q, sr_q[TDATA_WIDTH:1]};
            cnt_d = cnt_q + CW'(1);
        end else if (nb_q == 2'd2) begin
            sr_d  = {b1_q, b0_q, sr_q[TDATA_WIDTH:2]};
            cnt_d = cnt_q + CW'(2);
        end
        if (cnt_d == CW'(TDATA_WIDTH)) begin
            push_d = 1'b1;
            word_d = sr_d[TDATA_WIDTH:1];
            cnt_d  = '0;
        end else if (cnt_d == CW'(TDATA_WIDTH + 1)) begin
            push_d = 1'b1;
            word_d = sr_d[TDATA_WIDTH-1:0];
            cnt_d  = CW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            push_q <= 1'b0;
            word_q <= '0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            push_q <= push_d;
            word_q <= word_d;
        end
    end

    logic [TDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]            wr_q, rd_q;
    logic                   ovf_q;
    logic                   empty, full, pop, do_push;

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop     = !empty && m.m_tready;
        do_push = push_q && (!full || pop);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= word_q;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (pop) rd_q <= rd_q + (AW+1)'(1);
            if (push_q && full && !pop) ovf_q <= 1'b1;
        end
    end

    assign m.m_tvalid = !empty;
    assign m.m_tdata  = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_cdr_phase_tracker.sv
// tb/tb_cdr_phase_tracker.sv - randomized scoreboard bench for cdr_phase_tracker
module tb_cdr_phase_tracker;
    localparam int N = 4, W = 8, DEPTH = 4, LOCK = 16, MAXC = 4096;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [N-1:0] s_samples;
    logic         locked, overflow;
    logic [1:0]   phase;

    cdr_phase_tracker_if #(.TDATA_WIDTH(W)) axis ();

    cdr_phase_tracker #(
        .N_PHASES(N), .TDATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .LOCK_COUNT(LOCK)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .s_samples(s_samples), .m(axis),
        .locked(locked), .phase(phase), .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    logic         m_track;
    int           mp, mcnt, mpend;
    logic         mpend_v, mL;
    logic         bitq[$];
    int           due_q[$];
    logic [W-1:0] wq[$];
    int           exp_ph[MAXC];
    int           exp_lk[MAXC];

    task automatic model_clear();
        m_track = 1'b0; mp = 0; mcnt = 0; mpend = 0; mpend_v = 1'b0; mL = 1'b0;
        bitq.delete(); due_q.delete(); wq.delete();
    endtask

    task automatic model_word(input logic [N-1:0] w);
        int ne, e, c, oldp;
        logic prev;
        logic [W-1:0] word;
        ne = 0; e = 0; prev = mL;
        for (int i = 0; i < N; i++) begin
            if (w[i] != prev) begin ne++; e = i; end
            prev = w[i];
        end
        mL = w[N-1];
        c = (e + N / 2) % N;
        if (!m_track) begin
            if (ne == 1) begin
                m_track = 1'b1; mp = c; mcnt = 0; mpend_v = 1'b0;
                bitq.push_back(w[c]);
            end
        end else begin
            oldp = mp;
            if (ne == 1) begin
                if (c == mp) mpend_v = 1'b0;
                else begin
`ifdef CDR_PHASE_HYSTERESIS_EN
                    if (mpend_v && mpend == c) begin mp = c; mpend_v = 1'b0; end
                    else begin mpend = c; mpend_v = 1'b1; end
`else
                    mp = c;
`endif
                end
                if (mp != oldp) mcnt = 0;
                else if (mcnt < LOCK) mcnt++;
            end
            if (mp > oldp && mp - oldp > N / 2) begin
                bitq.push_back(w[oldp]);
                bitq.push_back(w[mp]);
            end else if (!(oldp > mp && oldp - mp > N / 2)) begin
                bitq.push_back(w[mp]);
            end
        end
        exp_ph[cyc+2] = mp;
        exp_lk[cyc+2] = (mcnt >= LOCK) ? 1 : 0;
        if (bitq.size() >= W) begin
            word = '0;
            for (int j = 0; j < W; j++) word[j] = bitq.pop_front();
            due_q.push_back(cyc + 4);
            wq.push_back(word);
        end
    endtask

    // Scoreboard monitor: model FIFO of expected words, compared away from the clock edge
    logic [W-1:0] sbq[$];
    logic         pop_pend = 1'b0;
    logic         exp_ovf  = 1'b0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("rst_tvalid", int'(axis.m_tvalid), 0);
            chk("rst_tdata", int'(axis.m_tdata), 0);
            chk("rst_locked", int'(locked), 0);
            chk("rst_phase", int'(phase), 0);
            chk("rst_overflow", int'(overflow), 0);
            sbq.delete();
            pop_pend = 1'b0;
            exp_ovf  = 1'b0;
        end else begin
            if (pop_pend) void'(sbq.pop_front());
            while (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                if (sbq.size() < DEPTH) sbq.push_back(wq.pop_front());
                else begin
                    void'(wq.pop_front());
                    exp_ovf = 1'b1;
                end
            end
            chk("tvalid", int'(axis.m_tvalid), int'(sbq.size() > 0));
            if (sbq.size() > 0) chk("tdata", int'(axis.m_tdata), int'(sbq[0]));
            chk("phase", int'(phase), exp_ph[cyc]);
            chk("locked", int'(locked), exp_lk[cyc]);
            chk("overflow", int'(overflow), int'(exp_ovf));
            pop_pend = (sbq.size() > 0) && axis.m_tready;
        end
    end

    logic tx_prev;

    task automatic drive(input logic [N-1:0] w, input logic rdy);
        @(posedge aclk); #1;
        s_samples     = w;
        axis.m_tready = rdy;
        model_word(w);
    endtask

    task automatic send_bit(input logic b, input int off, input logic rdy);
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) w[i] = (i < off) ? tx_prev : b;
        tx_prev = b;
        drive(w, rdy);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        model_clear();
        repeat (n) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tx_prev = 1'b0;
        exp_ph[cyc] = 0; exp_lk[cyc] = 0; exp_ph[cyc+1] = 0; exp_lk[cyc+1] = 0;
        s_samples = '0;
        model_word('0);
    endtask

    initial begin
        int off;
        logic [7:0] pat;
        logic [N-1:0] w;
        aresetn = 1'b1; s_samples = '0; axis.m_tready = 1'b1; tx_prev = 1'b0;
        model_clear();
        pulse_reset(3);

        for (int i = 0; i < 200; i++) send_bit(logic'(i % 2 == 0), 0, 1'b1);
        chk("nominal_phase", int'(phase), 2);
        chk("nominal_locked", int'(locked), 1);

        // One glitched word moves the edge by one sample
        send_bit(~tx_prev, 1, 1'b1);
        send_bit(~tx_prev, 0, 1'b1);
        send_bit(~tx_prev, 0, 1'b1);
`ifdef CDR_PHASE_HYSTERESIS_EN
        chk("glitch_phase", int'(phase), 2);
        chk("glitch_locked", int'(locked), 1);
`else
        chk("glitch_phase", int'(phase), 3);
        chk("glitch_locked", int'(locked), 0);
`endif
        for (int i = 0; i < 40; i++) send_bit(~tx_prev, 0, 1'b1);

        off = 0;
        for (int i = 0; i < 300; i++) begin
            if (i % 8 == 7) off = (off + N - 1) % N;
            send_bit(logic'($urandom_range(0, 1)), off, 1'b1);
        end

        pat = 8'hA5;
        for (int i = 0; i < 300; i++) begin
            if (i % 8 == 7) off = (off + 1) % N;
            send_bit(pat[i % 8], off, 1'b1);
        end

        for (int i = 0; i < 70; i++) send_bit(~tx_prev, off, 1'b0);
        chk("stall_overflow", int'(overflow), 1);
        for (int i = 0; i < 40; i++) send_bit(~tx_prev, off, 1'b1);
        chk("overflow_sticky", int'(overflow), 1);

        for (int i = 0; i < 5; i++) send_bit(logic'($urandom_range(0, 1)), off, 1'b1);
        pulse_reset(2);
        chk("post_reset_overflow", int'(overflow), 0);
        for (int i = 0; i < 60; i++) send_bit(logic'(i % 2 == 0), 0, 1'b1);
        chk("relock_phase", int'(phase), 2);
        chk("relock_locked", int'(locked), 1);

        off = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0)
                off = ($urandom_range(0, 1) == 1) ? (off + 1) % N : (off + N - 1) % N;
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < N; k++) w[k] = (k < off) ? tx_prev : ~tx_prev;
                w[$urandom_range(0, N - 1)] ^= 1'b1;
                tx_prev = w[N-1];
                drive(w, logic'($urandom_range(0, 3) != 0));
            end else begin
                send_bit(logic'($urandom_range(0, 1)), off, logic'($urandom_range(0, 3) != 0));
            end
        end

        for (int i = 0; i < 20; i++) send_bit(~tx_prev, off, 1'b1);
        @(negedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
